// File: rtl/tile_plotter.sv
// tile_plotter: raster pixel writer for the 160x120 VGA adapter.
// Sweeps one game tile or the whole screen, one pixel per clock.
module tile_plotter #(
  parameter int          TILE_SIZE = 20,
  parameter int          SCREEN_W  = 160,
  parameter int          SCREEN_H  = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_clear,
  input  logic [1:0] req_tile,
  input  logic [2:0] req_colour,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_CLEAR,
    S_DONE
  } state_t;

  localparam logic [7:0] TILE_LAST = 8'(TILE_SIZE - 1);
  localparam logic [7:0] W_LAST    = 8'(SCREEN_W - 1);
  localparam logic [7:0] H_LAST    = 8'(SCREEN_H - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_clear;
  logic [2:0] r_colour;
  logic [7:0] r_ox;
  logic [7:0] r_oy;
  logic [7:0] r_cx;
  logic [7:0] r_cy;

  logic       w_accept;
  logic       w_sweep;
  logic [7:0] w_last_x;
  logic [7:0] w_last_y;
  logic       w_x_end;
  logic       w_y_end;
  logic [7:0] w_ox;
  logic [7:0] w_oy;

  assign w_accept = req_valid & (r_state == S_IDLE);
  assign w_sweep  = (r_state == S_DRAW) | (r_state == S_CLEAR);
  assign w_last_x = r_clear ? W_LAST : TILE_LAST;
  assign w_last_y = r_clear ? H_LAST : TILE_LAST;
  assign w_x_end  = (r_cx == w_last_x);
  assign w_y_end  = (r_cy == w_last_y);

  // Tile index to screen origin; a clear sweeps from (0,0).
  always_comb begin
    w_ox = 8'd0;
    w_oy = 8'd0;
    if (!req_clear) begin
      unique case (req_tile)
        2'd0: begin w_ox = 8'd40;  w_oy = 8'd20; end
        2'd1: begin w_ox = 8'd100; w_oy = 8'd20; end
        2'd2: begin w_ox = 8'd40;  w_oy = 8'd70; end
        2'd3: begin w_ox = 8'd100; w_oy = 8'd70; end
        default: begin w_ox = 8'd0; w_oy = 8'd0; end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic: accept, sweep until the last pixel, one done cycle.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = req_clear ? S_CLEAR : S_DRAW;
      end
      S_DRAW, S_CLEAR: begin
        if (w_x_end && w_y_end) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch and raster counters; counters park on the last pixel
  // so x/y keep showing it until the next request.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_clear  <= 1'b0;
      r_colour <= 3'b000;
      r_ox     <= 8'd0;
      r_oy     <= 8'd0;
      r_cx     <= 8'd0;
      r_cy     <= 8'd0;
    end else if (w_accept) begin
      r_clear  <= req_clear;
      r_colour <= req_clear ? BG_COLOUR : req_colour;
      r_ox     <= w_ox;
      r_oy     <= w_oy;
      r_cx     <= 8'd0;
      r_cy     <= 8'd0;
    end else if (w_sweep && !(w_x_end && w_y_end)) begin
      if (w_x_end) begin
        r_cx <= 8'd0;
        r_cy <= r_cy + 8'd1;
      end else begin
        r_cx <= r_cx + 8'd1;
      end
    end
  end

  // Outputs decoded from registers only.
  always_comb begin
    req_ready = (r_state == S_IDLE);
    busy      = w_sweep;
    plot      = w_sweep;
    done      = (r_state == S_DONE);
    x         = r_ox + r_cx;
    y         = r_oy + r_cy;
    colour    = r_colour;
  end

endmodule

// File: tb/tb_tile_plotter.sv
// tb_tile_plotter: directed + random requests against a
// raster model, on a 20-pixel and a 2-pixel tile instance.
module tb_tile_plotter;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       valid0 = 1'b0;
  logic       valid1 = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] tile = 2'd0;
  logic [2:0] col = 3'd0;

  logic       rdy0, plot0, busy0, done0;
  logic [7:0] x0, y0;
  logic [2:0] c0;
  logic       rdy1, plot1, busy1, done1;
  logic [7:0] x1, y1;
  logic [2:0] c1;

  int checks = 0;
  int errors = 0;

  always #10 clock = ~clock;

  tile_plotter #(.TILE_SIZE(20)) u0 (
    .clock(clock), .resetn(resetn),
    .req_valid(valid0), .req_ready(rdy0),
    .req_clear(clr), .req_tile(tile), .req_colour(col),
    .x(x0), .y(y0), .colour(c0),
    .plot(plot0), .busy(busy0), .done(done0)
  );

  tile_plotter #(.TILE_SIZE(2)) u1 (
    .clock(clock), .resetn(resetn),
    .req_valid(valid1), .req_ready(rdy1),
    .req_clear(clr), .req_tile(tile), .req_colour(col),
    .x(x1), .y(y1), .colour(c1),
    .plot(plot1), .busy(busy1), .done(done1)
  );

  function automatic logic [21:0] obs(input bit sel);
    if (sel) return {plot1, busy1, done1, x1, y1, c1};
    return {plot0, busy0, done0, x0, y0, c0};
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? rdy1 : rdy0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Present a request from a negedge; returns #1 after the accept edge.
  task automatic request(input bit sel, input bit c_i,
                         input logic [1:0] t, input logic [2:0] cl,
                         input bit hold);
    int n;
    n = 0;
    clr = c_i; tile = t; col = cl;
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    while (!rdy(sel) && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("ready_at_request", 32'(rdy(sel)), 32'd1);
    @(posedge clock);
    #1;
    if (!hold) begin
      valid0 = 1'b0;
      valid1 = 1'b0;
    end
  endtask

  // Model of one full sweep, done pulse and return to idle.
  task automatic sweep(input bit sel, input bit c_i,
                       input logic [1:0] t, input logic [2:0] cl);
    int sz, w, n, ox, oy, ex, ey;
    logic [2:0] ec;
    sz = sel ? 2 : 20;
    w  = c_i ? 160 : sz;
    n  = c_i ? 160 * 120 : sz * sz;
    ox = c_i ? 0 : ((t[0]) ? 100 : 40);
    oy = c_i ? 0 : ((t[1]) ? 70 : 20);
    ec = c_i ? 3'b000 : cl;
    ex = 0; ey = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ex = ox + i % w;
      ey = oy + i / w;
      chk(c_i ? "clear_pixel" : "tile_pixel", 32'(obs(sel)),
          32'({1'b1, 1'b1, 1'b0, 8'(ex), 8'(ey), ec}));
    end
    @(negedge clock);
    chk("done_cycle", 32'(obs(sel)),
        32'({1'b0, 1'b0, 1'b1, 8'(ex), 8'(ey), ec}));
    chk("not_ready_in_done", 32'(rdy(sel)), 32'd0);
    @(negedge clock);
    chk("idle_hold", 32'(obs(sel)),
        32'({1'b0, 1'b0, 1'b0, 8'(ex), 8'(ey), ec}));
    chk("ready_again", 32'(rdy(sel)), 32'd1);
  endtask

  initial begin
    logic [1:0] rt;
    logic [2:0] rc;
    bit rs;

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset_u0", 32'(obs(0)), 32'd0);
    chk("reset_u1", 32'(obs(1)), 32'd0);
    chk("reset_rdy0", 32'(rdy0), 32'd1);
    resetn = 1'b1;
    @(negedge clock);
    chk("post_reset_u0", 32'(obs(0)), 32'd0);

    // Tile 1, colour 100, full size
    request(0, 0, 2'd1, 3'b100, 0);
    sweep(0, 0, 2'd1, 3'b100);

    // Small tiles back to back
    request(1, 0, 2'd3, 3'b010, 0);
    sweep(1, 0, 2'd3, 3'b010);
    request(1, 0, 2'd0, 3'b010, 0);
    sweep(1, 0, 2'd0, 3'b010);

    // Clear ignores the requested colour
    request(0, 1, 2'd2, 3'b111, 0);
    sweep(0, 1, 2'd2, 3'b111);

    // Tile 2 held on valid during a tile-0 sweep
    request(0, 0, 2'd0, 3'b011, 1);
    tile = 2'd2;
    col  = 3'b101;
    sweep(0, 0, 2'd0, 3'b011);
    request(0, 0, 2'd2, 3'b101, 0);
    sweep(0, 0, 2'd2, 3'b101);
    repeat (5) begin
      @(negedge clock);
      chk("no_extra_sweep", 32'({plot0, done0, rdy0}), 32'b001);
    end

    // Reset at pixel 150
    request(0, 0, 2'd3, 3'b110, 0);
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      chk("pre_abort_pixel", 32'(obs(0)),
          32'({1'b1, 1'b1, 1'b0, 8'(100 + i % 20),
               8'(70 + i / 20), 3'b110}));
    end
    @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_reset_out", 32'(obs(0)), 32'd0);
    chk("async_reset_rdy", 32'(rdy0), 32'd1);
    repeat (3) begin
      @(negedge clock);
      chk("no_done_in_reset", 32'(done0), 32'd0);
    end
    resetn = 1'b1;
    request(0, 0, 2'd2, 3'b001, 0);
    sweep(0, 0, 2'd2, 3'b001);

    // Random tile requests
    for (int k = 0; k < 8; k++) begin
      rs = 1'($urandom_range(0, 1));
      rt = 2'($urandom_range(0, 3));
      rc = 3'($urandom_range(0, 7));
      request(rs, 0, rt, rc, 0);
      sweep(rs, 0, rt, rc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_plotter.md
# tile_plotter

Pixel-writer front end for the 160x120 VGA framebuffer adapter. Accepts one draw request at a time over a valid/ready handshake: either one of the four game tiles in a given colour, or a full-screen clear. Sweeps the requested rectangle one pixel per clock, driving x/y/colour/plot into the adapter's write port, and pulses done on completion. Sits between the game control FSM and the VGA adapter; it replaces the per-tile datapath and counter enables.

## Interface
Parameters:
- TILE_SIZE, 20, side length of a tile in pixels; legal range 1..20.
- SCREEN_W, 160, clear-sweep width in pixels.
- SCREEN_H, 120, clear-sweep height in pixels.
- BG_COLOUR, 3'b000, colour written by a clear.

Ports. One clock; reset is asynchronous and active-low.
- clock  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_clear  in  1  1 = clear the screen; 0 = draw a tile.
- req_tile  in  2  tile index 0..3; ignored when req_clear=1.
- req_colour  in  3  RGB tile colour; ignored when req_clear=1.
- x  out  8  pixel column to the adapter.
- y  out  8  pixel row to the adapter.
- colour  out  3  pixel colour to the adapter.
- plot  out  1  write strobe; the adapter writes (x,y,colour) on every cycle plot=1.
- busy  out  1  1 while a sweep is in progress.
- done  out  1  one-cycle pulse after the last pixel.

## Operation
- FSM states: IDLE, DRAW, CLEAR, DONE.
- req_ready = (state==IDLE). A request is accepted on a rising edge with req_valid & req_ready.
- On accept, latch req_clear, req_colour and the tile origin (ox,oy), then zero the counters cx and cy (8 bits each).
- Tile origins:
  - tile 0 = (40,20)
  - tile 1 = (100,20)
  - tile 2 = (40,70)
  - tile 3 = (100,70)
- Accept transition: to CLEAR if req_clear=1, else to DRAW.
- DRAW:
  - plot=1, x=ox+cx, y=oy+cy, colour=latched colour.
  - Each cycle: if cx==TILE_SIZE-1 then cx←0, cy←cy+1; else cx←cx+1.
  - When cx==cy==TILE_SIZE-1, go to DONE.
- CLEAR:
  - Same raster with origin (0,0), width SCREEN_W, height SCREEN_H, colour=BG_COLOUR.
  - The last pixel is (SCREEN_W-1, SCREEN_H-1); then go to DONE.
- DONE: done=1, plot=0, then go to IDLE.
- Raster order is row-major: x advances fastest, y advances on x wrap.
- Arithmetic: ox+cx and oy+cy are 8-bit sums. With legal TILE_SIZE the maximum is 119, so no overflow occurs.
- busy = (state==DRAW | state==CLEAR).
- Outside DRAW/CLEAR: plot=0, and x/y/colour hold their last driven values.
- req_valid asserted while not ready is ignored, not queued. The requester holds req_valid and its request fields until accepted.
- req_valid must not be dropped before acceptance. If it is dropped, no request is registered.
- Reset mid-sweep: the sweep aborts immediately and no done pulse is issued. Partially written pixels remain in the framebuffer.

## Timing
- Reset values: state=IDLE, req_ready=1, x=0, y=0, colour=0, plot=0, busy=0, done=0, cx=cy=0.
- Accept at edge k. Plot cycles occupy the clock periods after edges k..k+N-1:
  - N = TILE_SIZE² for a tile.
  - N = SCREEN_W·SCREEN_H for a clear.
- done is high in the period after edge k+N. req_ready returns to 1 after edge k+N+1.
- Total request-to-next-ready: N+2 cycles.
  - Tile at default size: 402 cycles.
  - Clear: 19202 cycles.
- Minimum back-to-back spacing: a new request may be accepted on the first edge where req_ready=1.
- plot, x, y and colour change only on clock edges. They are decoded only from state, counter and latch registers; no input reaches an output combinationally.
- req_ready depends only on state, never combinationally on req_valid.

## Test plan
- Reset: hold resetn=0, toggle clock → req_ready=1, plot=0, busy=0, done=0, x=y=0, colour=0. Assert resetn=0 asynchronously between edges during DRAW → outputs return to these values without waiting for a clock edge.
- Tile draw, TILE_SIZE=20, req_tile=1, req_colour=3'b100 → exactly 400 plot cycles; first (100,20), 20th (119,20), 21st (100,21), last (119,39); all colour 3'b100; done pulses once, 401 cycles after accept.
- TILE_SIZE=2, req_tile=3, colour 3'b010 → plots (100,70), (101,70), (100,71), (101,71), then done. Re-request with tile 0 on the first ready edge → (40,20), (41,20), (40,21), (41,21).
- Clear with req_colour=3'b111 → 19200 plots; first (0,0), last (159,119); every colour = BG_COLOUR (000); busy high throughout; done once.
- Busy rejection: hold req_valid=1 with tile 2 during an active tile-0 sweep → tile-0 pixel stream is unchanged; tile 2 is accepted only after ready returns, and exactly one tile-2 sweep follows.
- Reset mid-sweep at pixel 150 of a tile → plot drops immediately, done never pulses. After release, a new request starts cleanly at the origin of its tile.
